uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
Parametrised UART receiver that supersedes the standalone parity generator. It oversamples the serial line, deframes start, data, parity and stop bits, and checks parity in all five modes. It reports parity, framing, break and overrun conditions, and delivers bytes over a valid/ready handshake to the bus-side register file or FIFO. Data width, parity mode, stop-bit count and oversampling ratio are set per instance.

Parameters:
- ClkFreq, 50_000_000: system clock frequency in Hz.
- BaudRate, 115200: line rate in baud.
- Oversample, 16: samples per bit; even, minimum 4.
- DataWidth, 8: data bits per frame, 5 to 9.
- ParityType, "none": one of "none", "even", "odd", "mark", "space".
- StopBits, 1: number of stop bits, 1 or 2.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- rx_i  input  1  serial line; asynchronous to clk_i; idles high.
- data_o  output  DataWidth  received word, LSB = first bit on the line.
- valid_o  output  1  data_o and the error flags are valid.
- ready_i  input  1  consumer accepts the word.
- parity_err_o  output  1  parity mismatch for the held word.
- frame_err_o  output  1  a stop bit was sampled low.
- break_o  output  1  break detected: all bits sampled 0, including parity and stop.
- overrun_o  output  1  one-cycle pulse when a completed frame is dropped.
- busy_o  output  1  receiver is not in IDLE.

Behaviour:
- Reset and width rules:
  - rst_ni low, asynchronously: state = IDLE, divider and counters = 0, synchroniser flops = 1.
  - Also on reset: data_o = 0, valid_o = 0, all error flags = 0, overrun_o = 0, busy_o = 0.
  - rx_i passes through a 2-flop synchroniser; all logic uses the synchronised value rx_s.
  - Tick divider: Div = ClkFreq/(BaudRate*Oversample), integer truncation, must be at least 1. A one-clock tick fires every Div clocks. The divider runs freely except in IDLE, where it is held at 0.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: when rx_s = 0, go to START; the divider and the sample counter clear.
- START: after Oversample/2 ticks (mid-bit), sample rx_s.
  - rx_s = 1: false start; return to IDLE with no output.
  - rx_s = 0: go to DATA.
- DATA: sample every Oversample ticks. Shift LSB first into the shift register. Go to PARITY after DataWidth samples, or straight to STOP when ParityType = "none".
- PARITY: sample one bit and compare it with the expected value.
  - "even": expected = XOR of the data bits.
  - "odd": expected = inverted XOR of the data bits.
  - "mark": expected = 1.
  - "space": expected = 0.
  - A mismatch sets the internal perr.
- STOP: sample StopBits stop bits, each Oversample ticks apart. Any stop bit sampled 0 sets the internal ferr. The frame completes on the clock after the last stop sample.
- Break: brk = ferr AND all data bits 0 AND (parity bit 0, or no parity).
- On completion:
  - valid_o = 0, or valid_o & ready_i in the same cycle: next cycle data_o, parity_err_o, frame_err_o and break_o load from the frame, and valid_o = 1.
  - Otherwise: the frame is discarded, the held word is untouched and overrun_o pulses for 1 cycle.
- After completion: go to WAIT_IDLE if ferr, otherwise IDLE. WAIT_IDLE stays until rx_s = 1, so a held-low break line yields exactly one report.
- Handshake: valid_o stays high until a cycle with ready_i = 1, then clears next cycle. data_o and the flags stay stable while valid_o = 1.
- busy_o = 1 in every state except IDLE.
- Latency: valid_o rises 2 clocks after the final stop mid-bit sample (1 clock to complete the frame, 1 clock to register the output), plus the synchroniser delay.
- Mid-frame reset: the partial frame is lost. After release the receiver waits in IDLE for a falling edge; it never resumes the partial frame.

Test Plan:
- 8N1, Div = 27: send 0xA5 with ready_i = 1. Required: data_o = 0xA5, valid_o high for exactly 1 cycle, all error flags 0.
- Even parity, 0x03 sent with parity bit 1 (correct bit is 0). Required: parity_err_o = 1, frame_err_o = 0, data_o = 0x03.
- A 0.3-bit low glitch on idle rx_i. Required: no valid_o; busy_o returns to 0 by mid-start plus 1 clock.
- rx_i held low for 3 frame times. Required: exactly one valid_o with data_o = 0x00, frame_err_o = 1 and break_o = 1. The next frame, 0x5A, is received cleanly after the line returns high.
- ready_i = 0; send 0x11 then 0x22. Required: valid_o holds data_o = 0x11, overrun_o pulses once at the second completion, and raising ready_i drops valid_o with no 0x22 delivered.
- 7O2 configuration, rst_ni pulsed low during DATA. Required: all outputs go to 0 immediately. The next full frame, 0x7F with parity bit 0 and 2 stop bits, is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with start/data/parity/stop
// deframing, parity/framing/break/overrun reporting and a valid/ready
// output handshake. Frame format and timing are fixed per instance.
module uart_rx_frame #(
    parameter int    ClkFreq    = 50_000_000,
    parameter int    BaudRate   = 115200,
    parameter int    Oversample = 16,
    parameter int    DataWidth  = 8,
    parameter string ParityType = "none",
    parameter int    StopBits   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int  Div       = ClkFreq / (BaudRate * Oversample);
    localparam int  DivW      = (Div > 1) ? $clog2(Div) : 1;
    localparam int  TickW     = $clog2(Oversample + 1);
    localparam int  BitW      = 4;
    localparam bit  HasParity = (ParityType != "none");

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_e;

    // Parity bit the transmitter should have sent for a given data word.
    function automatic logic expected_parity(input logic [DataWidth-1:0] d);
        logic x;
        x = ^d;
        if (ParityType == "even") begin
            return x;
        end else if (ParityType == "odd") begin
            return ~x;
        end else if (ParityType == "mark") begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

    state_e               state_r, state_s;
    logic                 rx_meta_r, rx_sync_r, rx_s;
    logic [DivW-1:0]      div_cnt_r;
    logic [TickW-1:0]     tick_cnt_r;
    logic [BitW-1:0]      bit_cnt_r;
    logic [DataWidth-1:0] shift_r;
    logic                 par_bit_r, perr_r, ferr_r, done_r;
    logic [DataWidth-1:0] data_r;
    logic                 valid_r, perr_out_r, ferr_out_r, brk_out_r, overrun_r, busy_r;

    logic                 tick_s, sample_s, brk_s;
    logic [TickW-1:0]     tick_target_s;
    logic                 last_data_s, last_stop_s;
    logic                 start_smp_s, data_smp_s, par_smp_s, stop_smp_s, frame_end_s;

    assign rx_s = rx_sync_r;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_i;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Tick and sample-point decode; START samples at half a bit, others every full bit.
    always_comb begin
        tick_s        = (state_r != ST_IDLE) && (div_cnt_r == DivW'(Div - 1));
        tick_target_s = (state_r == ST_START) ? TickW'(Oversample / 2) : TickW'(Oversample);
        sample_s      = tick_s && (tick_cnt_r == (tick_target_s - TickW'(1)));
        last_data_s   = (bit_cnt_r == BitW'(DataWidth - 1));
        last_stop_s   = (bit_cnt_r == BitW'(StopBits - 1));
    end

    // Baud tick divider; held at zero while idle so a start edge restarts bit timing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_r <= '0;
        end else if ((state_r == ST_IDLE) || tick_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DivW'(1);
        end
    end

    // Ticks elapsed within the current bit; restarts at every sample point.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt_r <= '0;
        end else if ((state_r == ST_IDLE) || sample_s) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= tick_cnt_r + TickW'(1);
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; STOP lingers one clock after its last sample to complete the frame.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:      state_s = rx_s ? ST_IDLE : ST_START;
            ST_START:     state_s = sample_s ? (rx_s ? ST_IDLE : ST_DATA) : ST_START;
            ST_DATA:      state_s = (sample_s && last_data_s) ? (HasParity ? ST_PARITY : ST_STOP) : ST_DATA;
            ST_PARITY:    state_s = sample_s ? ST_STOP : ST_PARITY;
            ST_STOP:      state_s = done_r ? (ferr_r ? ST_WAIT_IDLE : ST_IDLE) : ST_STOP;
            ST_WAIT_IDLE: state_s = rx_s ? ST_IDLE : ST_WAIT_IDLE;
            default:      state_s = ST_IDLE;
        endcase
    end

    // FSM output decode: per-state sample strobes for the datapath.
    always_comb begin
        start_smp_s = 1'b0;
        data_smp_s  = 1'b0;
        par_smp_s   = 1'b0;
        stop_smp_s  = 1'b0;
        frame_end_s = 1'b0;
        case (state_r)
            ST_START:  start_smp_s = sample_s;
            ST_DATA:   data_smp_s  = sample_s;
            ST_PARITY: par_smp_s   = sample_s;
            ST_STOP: begin
                stop_smp_s  = sample_s && !done_r;
                frame_end_s = sample_s && !done_r && last_stop_s;
            end
            default: begin
                start_smp_s = 1'b0;
            end
        endcase
    end

    // Bit counter for data and stop bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_r <= '0;
        end else if ((state_r == ST_IDLE) || (data_smp_s && last_data_s) || frame_end_s) begin
            bit_cnt_r <= '0;
        end else if (data_smp_s || stop_smp_s) begin
            bit_cnt_r <= bit_cnt_r + BitW'(1);
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Frame datapath: shift register, parity capture, error accumulation, completion strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_r   <= '0;
            par_bit_r <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= frame_end_s;
            if (start_smp_s) begin
                par_bit_r <= 1'b0;
                perr_r    <= 1'b0;
                ferr_r    <= 1'b0;
            end else if (data_smp_s) begin
                shift_r <= {rx_s, shift_r[DataWidth-1:1]};
            end else if (par_smp_s) begin
                par_bit_r <= rx_s;
                perr_r    <= (rx_s != expected_parity(shift_r));
            end else if (stop_smp_s && !rx_s) begin
                ferr_r <= 1'b1;
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    assign brk_s = ferr_r && (shift_r == '0) && (!HasParity || !par_bit_r);

    // Output holding register with valid/ready handshake and overrun pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_r     <= '0;
            valid_r    <= 1'b0;
            perr_out_r <= 1'b0;
            ferr_out_r <= 1'b0;
            brk_out_r  <= 1'b0;
            overrun_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            if (done_r && (!valid_r || ready_i)) begin
                data_r     <= shift_r;
                perr_out_r <= perr_r;
                ferr_out_r <= ferr_r;
                brk_out_r  <= brk_s;
                valid_r    <= 1'b1;
                overrun_r  <= 1'b0;
            end else if (done_r) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= 1'b0;
                if (valid_r && ready_i) begin
                    valid_r <= 1'b0;
                end else begin
                    valid_r <= valid_r;
                end
            end
        end
    end

    assign data_o       = data_r;
    assign valid_o      = valid_r;
    assign parity_err_o = perr_out_r;
    assign frame_err_o  = ferr_out_r;
    assign break_o      = brk_out_r;
    assign overrun_o    = overrun_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three configurations (8N1, 8E1, 7O2) driven by a
// bit-level frame generator and checked against a frame-level reference model.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rx, rdy;
    logic [2:0] vld, pe, fe, bk, ov, bsy;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [8:0] dat [3];

    int errors = 0;
    int checks = 0;

    // Per-instance frame format and bit period in clocks.
    int nbits [3] = '{8, 8, 7};
    int pmode [3] = '{0, 1, 2};     // 0 none, 1 even, 2 odd
    int nstop [3] = '{1, 1, 2};
    int bclk  [3] = '{432, 216, 216};

    int vcnt [3] = '{0, 0, 0};
    int ocnt [3] = '{0, 0, 0};
    logic [13:0] cap_q [$];

    always #5 clk = ~clk;

    uart_rx_frame #(.ClkFreq(50_000_000), .BaudRate(115200), .Oversample(16),
                    .DataWidth(8), .ParityType("none"), .StopBits(1)) u_8n1 (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx[0]), .data_o(d0), .valid_o(vld[0]),
        .ready_i(rdy[0]), .parity_err_o(pe[0]), .frame_err_o(fe[0]), .break_o(bk[0]),
        .overrun_o(ov[0]), .busy_o(bsy[0]));

    uart_rx_frame #(.ClkFreq(50_000_000), .BaudRate(230400), .Oversample(8),
                    .DataWidth(8), .ParityType("even"), .StopBits(1)) u_8e1 (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx[1]), .data_o(d1), .valid_o(vld[1]),
        .ready_i(rdy[1]), .parity_err_o(pe[1]), .frame_err_o(fe[1]), .break_o(bk[1]),
        .overrun_o(ov[1]), .busy_o(bsy[1]));

    uart_rx_frame #(.ClkFreq(50_000_000), .BaudRate(230400), .Oversample(8),
                    .DataWidth(7), .ParityType("odd"), .StopBits(2)) u_7o2 (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx[2]), .data_o(d2), .valid_o(vld[2]),
        .ready_i(rdy[2]), .parity_err_o(pe[2]), .frame_err_o(fe[2]), .break_o(bk[2]),
        .overrun_o(ov[2]), .busy_o(bsy[2]));

    assign dat[0] = {1'b0, d0};
    assign dat[1] = {1'b0, d1};
    assign dat[2] = {2'b00, d2};

    // Monitor: count valid cycles and overrun pulses, log every accepted word.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i]) vcnt[i] <= vcnt[i] + 1;
            if (ov[i]) ocnt[i] <= ocnt[i] + 1;
            if (vld[i] && rdy[i]) cap_q.push_back({2'(i), bk[i], fe[i], pe[i], dat[i]});
        end
    end

    // Reference model: what one received frame should report, from the frame rules.
    function automatic logic [13:0] model_frame(input int idx, input logic [8:0] d_in,
                                                input logic pbit, input logic [1:0] stops);
        logic [8:0] d;
        logic x, e, perr, ferr, brk;
        d = d_in & ((9'h001 << nbits[idx]) - 9'h001);
        x = ^d;
        case (pmode[idx])
            1:       e = x;
            2:       e = !x;
            default: e = 1'b0;
        endcase
        perr = (pmode[idx] != 0) && (pbit != e);
        ferr = (nstop[idx] == 2) ? !(stops[0] && stops[1]) : !stops[0];
        brk  = ferr && (d == 9'h000) && ((pmode[idx] == 0) || !pbit);
        return {2'(idx), brk, ferr, perr, d};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int idx, input logic [8:0] d, input logic pbit,
                              input logic [1:0] stops);
        rx[idx] = 1'b0;
        wait_clk(bclk[idx]);
        for (int i = 0; i < nbits[idx]; i++) begin
            rx[idx] = d[i];
            wait_clk(bclk[idx]);
        end
        if (pmode[idx] != 0) begin
            rx[idx] = pbit;
            wait_clk(bclk[idx]);
        end
        for (int s = 0; s < nstop[idx]; s++) begin
            rx[idx] = stops[s];
            wait_clk(bclk[idx]);
        end
        rx[idx] = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({vld[i], pe[i], fe[i], bk[i], ov[i], bsy[i]} !== 6'b000000) begin
                errors++;
                $display("FAIL reset_flags[%0d]: got %b expected 000000", i,
                         {vld[i], pe[i], fe[i], bk[i], ov[i], bsy[i]});
            end
            checks++;
            if (dat[i] !== 9'h000) begin
                errors++;
                $display("FAIL reset_data[%0d]: got %h expected 000", i, dat[i]);
            end
        end
    endtask

    task automatic test_8n1_basic();
        logic [8:0]  d;
        logic [13:0] exp;
        int qb, vb, ob;
        for (int k = 0; k < 4; k++) begin
            d   = (k == 0) ? 9'h0A5 : 9'($urandom_range(0, 255));
            exp = model_frame(0, d, 1'b0, 2'b11);
            qb = cap_q.size(); vb = vcnt[0]; ob = ocnt[0];
            send_frame(0, d, 1'b0, 2'b11);
            wait_clk(20);
            checks++;
            if (cap_q.size() != qb + 1) begin
                errors++;
                $display("FAIL 8n1_count: got %0d words expected 1", cap_q.size() - qb);
            end else begin
                checks++;
                if (cap_q[qb] !== exp) begin
                    errors++;
                    $display("FAIL 8n1_word: got %h expected %h", cap_q[qb], exp);
                end
            end
            checks++;
            if (vcnt[0] - vb != 1) begin
                errors++;
                $display("FAIL 8n1_valid_len: got %0d cycles expected 1", vcnt[0] - vb);
            end
            checks++;
            if (ocnt[0] != ob) begin
                errors++;
                $display("FAIL 8n1_overrun: got %0d pulses expected 0", ocnt[0] - ob);
            end
        end
    endtask

    task automatic test_even_parity();
        logic [8:0]  d;
        logic        pb;
        logic [13:0] exp;
        int qb;
        for (int k = 0; k < 4; k++) begin
            d  = (k == 0) ? 9'h003 : 9'($urandom_range(0, 255));
            pb = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            exp = model_frame(1, d, pb, 2'b11);
            qb = cap_q.size();
            send_frame(1, d, pb, 2'b11);
            wait_clk(20);
            checks++;
            if (cap_q.size() != qb + 1) begin
                errors++;
                $display("FAIL par_count: got %0d words expected 1", cap_q.size() - qb);
            end else begin
                checks++;
                if (cap_q[qb] !== exp) begin
                    errors++;
                    $display("FAIL par_word: got %h expected %h", cap_q[qb], exp);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int qb, vb;
        qb = cap_q.size(); vb = vcnt[0];
        rx[0] = 1'b0;
        wait_clk(60);
        checks++;
        if (bsy[0] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_on: got %b expected 1", bsy[0]);
        end
        wait_clk(70);
        rx[0] = 1'b1;
        wait_clk(130);
        checks++;
        if (bsy[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_off: got %b expected 0", bsy[0]);
        end
        wait_clk(bclk[0]);
        checks++;
        if ((cap_q.size() != qb) || (vcnt[0] != vb)) begin
            errors++;
            $display("FAIL glitch_no_valid: got %0d valid cycles expected 0", vcnt[0] - vb);
        end
    endtask

    task automatic test_break();
        logic [13:0] exp;
        int qb;
        qb = cap_q.size();
        rx[0] = 1'b0;
        wait_clk(3 * 10 * bclk[0]);
        rx[0] = 1'b1;
        wait_clk(bclk[0]);
        exp = model_frame(0, 9'h000, 1'b0, 2'b00);
        checks++;
        if (cap_q.size() != qb + 1) begin
            errors++;
            $display("FAIL break_count: got %0d words expected 1", cap_q.size() - qb);
        end else begin
            checks++;
            if (cap_q[qb] !== exp) begin
                errors++;
                $display("FAIL break_word: got %h expected %h", cap_q[qb], exp);
            end
        end
        qb = cap_q.size();
        exp = model_frame(0, 9'h05A, 1'b0, 2'b11);
        send_frame(0, 9'h05A, 1'b0, 2'b11);
        wait_clk(20);
        checks++;
        if ((cap_q.size() != qb + 1) || (cap_q[qb] !== exp)) begin
            errors++;
            $display("FAIL break_recover: got %0d words expected 1 of %h", cap_q.size() - qb, exp);
        end
    endtask

    task automatic test_overrun();
        logic [13:0] exp;
        int qb, ob;
        qb = cap_q.size(); ob = ocnt[0];
        rdy[0] = 1'b0;
        send_frame(0, 9'h011, 1'b0, 2'b11);
        wait_clk(20);
        send_frame(0, 9'h022, 1'b0, 2'b11);
        wait_clk(20);
        checks++;
        if ((vld[0] !== 1'b1) || (dat[0] !== 9'h011)) begin
            errors++;
            $display("FAIL ovr_hold: got valid=%b data=%h expected valid=1 data=011", vld[0], dat[0]);
        end
        checks++;
        if (ocnt[0] - ob != 1) begin
            errors++;
            $display("FAIL ovr_pulse: got %0d pulses expected 1", ocnt[0] - ob);
        end
        rdy[0] = 1'b1;
        wait_clk(5);
        exp = model_frame(0, 9'h011, 1'b0, 2'b11);
        checks++;
        if (vld[0] !== 1'b0) begin
            errors++;
            $display("FAIL ovr_drop: got valid=%b expected 0", vld[0]);
        end
        checks++;
        if ((cap_q.size() != qb + 1) || (cap_q[qb] !== exp)) begin
            errors++;
            $display("FAIL ovr_word: got %0d words expected 1 of %h", cap_q.size() - qb, exp);
        end
    endtask

    task automatic test_7o2_reset();
        logic [8:0]  d;
        logic [13:0] exp;
        int qb;
        rdy[2] = 1'b0;
        d = 9'($urandom_range(1, 127));
        send_frame(2, d, ~^d[6:0], 2'b11);
        wait_clk(20);
        checks++;
        if (vld[2] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_valid: got %b expected 1", vld[2]);
        end
        rx[2] = 1'b0;
        wait_clk(bclk[2]);
        for (int i = 0; i < 3; i++) begin
            rx[2] = 1'($urandom_range(0, 1));
            wait_clk(bclk[2]);
        end
        wait_clk(50);
        checks++;
        if (bsy[2] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_busy: got %b expected 1", bsy[2]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (({vld[2], pe[2], fe[2], bk[2], ov[2], bsy[2]} !== 6'b000000) || (dat[2] !== 9'h000)) begin
            errors++;
            $display("FAIL rst_async: got flags=%b data=%h expected 000000/000",
                     {vld[2], pe[2], fe[2], bk[2], ov[2], bsy[2]}, dat[2]);
        end
        rx[2] = 1'b1;
        wait_clk(5);
        rst_n  = 1'b1;
        rdy[2] = 1'b1;
        qb = cap_q.size();
        wait_clk(2 * bclk[2]);
        checks++;
        if ((vld[2] !== 1'b0) || (cap_q.size() != qb)) begin
            errors++;
            $display("FAIL rst_no_resume: got valid=%b expected 0", vld[2]);
        end
        exp = model_frame(2, 9'h07F, 1'b0, 2'b11);
        send_frame(2, 9'h07F, 1'b0, 2'b11);
        wait_clk(20);
        checks++;
        if ((cap_q.size() != qb + 1) || (cap_q[qb] !== exp)) begin
            errors++;
            $display("FAIL 7o2_word: got %0d words expected 1 of %h", cap_q.size() - qb, exp);
        end
        qb = cap_q.size();
        d = 9'($urandom_range(1, 127));
        exp = model_frame(2, d, ~^d[6:0], 2'b01);
        send_frame(2, d, ~^d[6:0], 2'b01);
        wait_clk(20);
        checks++;
        if ((cap_q.size() != qb + 1) || (cap_q[qb] !== exp)) begin
            errors++;
            $display("FAIL 7o2_stop2: got %0d words expected 1 of %h", cap_q.size() - qb, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 3'b111;
        rdy   = 3'b111;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);
        test_reset();
        test_8n1_basic();
        test_even_parity();
        test_glitch();
        test_break();
        test_overrun();
        test_7o2_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
